// File: rtl/tamagotchi_pkg.sv
// Shared state codes and select-FSM encoding for the pet front-end.
// Pure constants plus a cursor wrap helper; no timing, no flow control.
package tamagotchi_pkg;

    localparam logic [2:0] SALUD     = 3'd0;
    localparam logic [2:0] HAMBRE    = 3'd1;
    localparam logic [2:0] SUENO     = 3'd2;
    localparam logic [2:0] FELICIDAD = 3'd3;
    localparam logic [2:0] HIGIENE   = 3'd4;
    localparam logic [2:0] CONDICION = 3'd5;
    localparam logic [2:0] MUERTO    = 3'd6;
    localparam logic [2:0] NO_CHANGE = 3'd7;

    localparam int N_SELECTABLE = 6;

    localparam logic [1:0] SEL_IDLE      = 2'd0;
    localparam logic [1:0] SEL_HOLD      = 2'd1;
    localparam logic [1:0] SEL_LONG_WAIT = 2'd2;

    // MUERTO is not selectable, so the cursor wraps from the last selectable code to SALUD
    function automatic logic [2:0] cursor_next(input logic [2:0] cur);
        return (cur == 3'(N_SELECTABLE - 1)) ? SALUD : cur + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF synchroniser -> counter debounce; level output.
// Latency 2 + DEBOUNCE_CYCLES cycles per clean edge; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_deb
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_deb  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            // any cycle where the synchronised level agrees with r_deb restarts the count
            if (r_sync != r_deb) begin
                if (r_cnt == CNT_LAST) begin
                    r_deb <= r_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/tamagotchi_input_ctrl.sv
// Two buttons -> cursor over selectable states, short-press command, long-press reset request.
// Outputs registered one cycle after the debounced edge strobe; no backpressure.
module tamagotchi_input_ctrl
    import tamagotchi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int LONG_PRESS_CYCLES = 8,
    parameter int CNT_W             = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_select,
    input  logic [2:0] active_state,
    output logic [2:0] change_state,
    output logic       rst_req,
    output logic [2:0] cursor
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

    logic             w_next_deb;
    logic             w_sel_deb;
    logic             w_next_rise;
    logic             w_sel_rise;
    logic             w_sel_fall;
    logic             w_dead;

    logic             r_next_prev;
    logic             r_sel_prev;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [2:0]       r_cursor;
    logic [2:0]       r_change;
    logic             r_rst_req;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_next (
        .clk  (clk),
        .rst  (rst),
        .i_btn(btn_next),
        .o_deb(w_next_deb)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_select (
        .clk  (clk),
        .rst  (rst),
        .i_btn(btn_select),
        .o_deb(w_sel_deb)
    );

    assign w_next_rise = w_next_deb & ~r_next_prev;
    assign w_sel_rise  = w_sel_deb & ~r_sel_prev;
    assign w_sel_fall  = ~w_sel_deb & r_sel_prev;
    assign w_dead      = (active_state == MUERTO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_prev <= 1'b0;
            r_sel_prev  <= 1'b0;
            r_state     <= SEL_IDLE;
            r_hold_cnt  <= '0;
            r_cursor    <= SUENO;
            r_change    <= NO_CHANGE;
            r_rst_req   <= 1'b0;
        end else begin
            r_next_prev <= w_next_deb;
            r_sel_prev  <= w_sel_deb;
            r_change    <= NO_CHANGE;
            r_rst_req   <= 1'b0;

            case (r_state)
                SEL_IDLE: begin
                    // a select rise in the same cycle swallows any next rise
                    if (w_sel_rise) begin
                        r_state    <= SEL_HOLD;
                        r_hold_cnt <= CNT_W'(1);
                    end else if (w_next_rise && !w_dead) begin
                        r_cursor <= cursor_next(r_cursor);
                    end
                end
                SEL_HOLD: begin
                    if (w_sel_fall) begin
                        r_state <= SEL_IDLE;
                        if (!w_dead) begin
                            r_change <= r_cursor;
                        end
                    end else if (w_sel_deb) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_rst_req  <= 1'b1;
                            r_cursor   <= SUENO;
                            r_state    <= SEL_LONG_WAIT;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                        end
                    end
                end
                SEL_LONG_WAIT: begin
                    if (w_sel_fall) begin
                        r_state <= SEL_IDLE;
                    end
                end
                default: begin
                    r_state <= SEL_IDLE;
                end
            endcase
        end
    end

    assign change_state = r_change;
    assign rst_req      = r_rst_req;
    assign cursor       = r_cursor;

endmodule

// File: tb/tb_tamagotchi_input_ctrl.sv
// Bench for tamagotchi_input_ctrl: directed scenarios with literal expectations, then random
// button/state traffic, all checked every cycle against a window-based behavioural model.
module tb_tamagotchi_input_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 8;
    localparam int HL   = DEB + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_select = 1'b0;
    logic [2:0] active_state = 3'd0;
    logic [2:0] change_state;
    logic       rst_req;
    logic [2:0] cursor;

    always #5 clk = ~clk;

    tamagotchi_input_ctrl #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .CNT_W            (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_next    (btn_next),
        .btn_select  (btn_select),
        .active_state(active_state),
        .change_state(change_state),
        .rst_req     (rst_req),
        .cursor      (cursor)
    );

    int total = 0;
    int bad   = 0;
    int nprint = 0;

    // Model: raw sample history per button (index 0 = this edge); the synchronised value seen at
    // an edge is the raw sample from two edges earlier, and the debounced level flips once the
    // last DEB synchronised values all disagree with it.
    bit [HL-1:0] m_hn, m_hs;
    bit m_deb_n, m_deb_s, m_prev_n, m_prev_s;
    int m_mode;       // 0 idle, 1 holding, 2 waiting for release after long press
    int m_len;        // debounced-high cycles of the current select press
    int m_cursor;
    int m_cs;
    bit m_rr;
    bit m_valid = 1'b0;

    int cs_cnt, cs_val, rr_cnt;

    function automatic bit window_flip(input bit [HL-1:0] h, input bit lvl);
        for (int k = 2; k < HL; k++)
            if (h[k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit nr, sr, sf;
        int mode0;
        if (rst) begin
            m_hn = '0; m_hs = '0;
            m_deb_n = 0; m_deb_s = 0; m_prev_n = 0; m_prev_s = 0;
            m_mode = 0; m_len = 0; m_cursor = 2; m_cs = 7; m_rr = 0;
            m_valid = 1'b1;
        end else begin
            m_hn = {m_hn[HL-2:0], btn_next};
            m_hs = {m_hs[HL-2:0], btn_select};
            nr = m_deb_n && !m_prev_n;
            sr = m_deb_s && !m_prev_s;
            sf = !m_deb_s && m_prev_s;
            m_cs = 7;
            m_rr = 0;
            mode0 = m_mode;
            if (m_mode == 0) begin
                if (sr) begin m_mode = 1; m_len = 1; end
            end else if (m_mode == 1) begin
                if (sf) begin
                    m_mode = 0;
                    if (active_state != 3'd6) m_cs = m_cursor;
                end else if (m_deb_s) begin
                    m_len++;
                    if (m_len == LONG) begin m_rr = 1; m_cursor = 2; m_mode = 2; end
                end
            end else if (sf) begin
                m_mode = 0;
            end
            if (mode0 == 0 && nr && !sr && active_state != 3'd6)
                m_cursor = (m_cursor + 1) % 6;
            m_prev_n = m_deb_n;
            m_prev_s = m_deb_s;
            if (window_flip(m_hn, m_deb_n)) m_deb_n = !m_deb_n;
            if (window_flip(m_hs, m_deb_s)) m_deb_s = !m_deb_s;
        end
    endtask

    // One clock: advance the model on the current inputs, let the edge pass, compare.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (m_valid) begin
            total++;
            if (cursor !== 3'(m_cursor) || change_state !== 3'(m_cs) || rst_req !== m_rr) begin
                bad++;
                if (nprint < 20)
                    $display("FAIL model_cmp t=%0t cursor=%0d exp=%0d change_state=%0d exp=%0d rst_req=%0b exp=%0b",
                             $time, cursor, m_cursor, change_state, m_cs, rst_req, m_rr);
                nprint++;
            end
        end
        if (change_state !== 3'd7) begin cs_cnt++; cs_val = int'(change_state); end
        if (rst_req !== 1'b0) rr_cnt++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic clr_obs();
        cs_cnt = 0; cs_val = -1; rr_cnt = 0;
    endtask

    task automatic press_next();
        btn_next = 1'b1; steps(10);
        btn_next = 1'b0; steps(10);
    endtask

    task automatic press_select(input int hi);
        btn_select = 1'b1; steps(hi);
        btn_select = 1'b0; steps(20);
    endtask

    int n, first_rr;
    int left_n, left_s;

    initial begin
        // 1: reset and idle
        rst = 1'b1; step(); rst = 1'b0;
        check("reset_cursor", int'(cursor), 2);
        check("reset_change_state", int'(change_state), 7);
        check("reset_rst_req", int'(rst_req), 0);
        clr_obs();
        steps(20);
        check("idle_cursor", int'(cursor), 2);
        check("idle_cmd_pulses", cs_cnt + rr_cnt, 0);

        // 2: cursor stepping with wrap; first press also measures latency
        btn_next = 1'b1; step();
        n = 0;
        while (cursor === 3'd2 && n < 20) begin step(); n++; end
        check("next_latency", n, 6);
        steps(9 - n);
        btn_next = 1'b0; steps(10);
        check("cursor_after_1", int'(cursor), 3);
        press_next(); check("cursor_after_2", int'(cursor), 4);
        press_next(); check("cursor_after_3", int'(cursor), 5);
        press_next(); check("cursor_wrap", int'(cursor), 0);
        repeat (4) press_next();
        check("cursor_at_4", int'(cursor), 4);

        // 3: short select
        clr_obs();
        press_select(5);
        check("short_cmd_count", cs_cnt, 1);
        check("short_cmd_value", cs_val, 4);
        check("short_no_rst_req", rr_cnt, 0);

        // 4: long select
        clr_obs();
        btn_select = 1'b1;
        first_rr = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (rst_req === 1'b1 && first_rr < 0) first_rr = i;
        end
        btn_select = 1'b0; steps(20);
        check("long_rr_latency", first_rr, 14);
        check("long_rr_count", rr_cnt, 1);
        check("long_cursor", int'(cursor), 2);
        check("long_no_cmd", cs_cnt, 0);

        // 5: glitches, then both buttons together
        press_next();
        for (int g = 1; g <= 3; g++) begin
            btn_next = 1'b1; steps(g);
            btn_next = 1'b0; steps(10);
        end
        check("glitch_cursor", int'(cursor), 3);
        clr_obs();
        btn_next = 1'b1; btn_select = 1'b1; steps(5);
        btn_next = 1'b0; btn_select = 1'b0; steps(20);
        check("both_cursor", int'(cursor), 3);
        check("both_cmd_count", cs_cnt, 1);
        check("both_cmd_value", cs_val, 3);

        // 6: dead pet
        active_state = 3'd6;
        clr_obs();
        press_next();
        check("dead_cursor", int'(cursor), 3);
        press_select(5);
        check("dead_no_cmd", cs_cnt, 0);
        press_select(30);
        check("dead_long_rr", rr_cnt, 1);
        check("dead_long_cursor", int'(cursor), 2);
        active_state = 3'd0;

        // reset during HOLD
        press_next();
        clr_obs();
        btn_select = 1'b1; steps(9);
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_cursor", int'(cursor), 2);
        check("midrst_change_state", int'(change_state), 7);
        check("midrst_rst_req", int'(rst_req), 0);
        steps(3); btn_select = 1'b0; steps(20);
        check("midrst_no_pulses", cs_cnt + rr_cnt, 0);

        // random traffic against the model
        left_n = 0; left_s = 0;
        for (int c = 0; c < 4000; c++) begin
            if (left_n == 0) begin
                btn_next = 1'($urandom_range(0, 1));
                left_n = $urandom_range(1, 14);
            end
            if (left_s == 0) begin
                btn_select = 1'($urandom_range(0, 1));
                left_s = $urandom_range(1, 20);
            end
            if (c % 50 == 0)
                active_state = ($urandom_range(0, 4) == 0) ? 3'd6 : 3'($urandom_range(0, 5));
            rst = ($urandom_range(0, 399) == 0);
            step();
            left_n--; left_s--;
        end
        rst = 1'b0;
        steps(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tamagotchi_input_ctrl.md
Name: tamagotchi_input_ctrl

Overview:
- Front-end command generator that drives the pet state machine's `change_state` input and reads back its `active_state`.
- Turns two raw push-buttons (`btn_next`, `btn_select`) into a scrollable cursor over the six selectable states.
- A short select press issues a one-cycle state-change command; a long select press issues a one-cycle reset request.
- Sits between the board buttons and the pet FSM; drives `NO_CHANGE` (3'd7) whenever no command is pending.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from the debounced level before that level flips (min 1).
- LONG_PRESS_CYCLES, 8, debounced-high cycles of `btn_select` that qualify as a long press (min 2).
- CNT_W, 16, width of the internal debounce and hold counters; must hold both parameter values.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- btn_next  in  1  raw, asynchronous, active-high "move cursor" button
- btn_select  in  1  raw, asynchronous, active-high "confirm / long-press reset" button
- active_state  in  3  current state reported by the pet FSM (6 = MUERTO)
- change_state  out  3  command to the pet FSM; cursor value for one cycle, else 3'd7
- rst_req  out  1  one-cycle pulse requesting a pet reset
- cursor  out  3  currently highlighted state, range 0..5

Behaviour:
- Reset is synchronous: on any posedge `clk` with `rst`=1, all state clears.
  - `change_state`=3'd7, `rst_req`=0, `cursor`=2 (SUENO).
  - Debounced levels=0, counters=0, select FSM=IDLE.
- Synchronisation: each button passes a 2-FF synchroniser; synchroniser flops are also cleared by `rst`.
- Debounce, per button:
  - If sync != deb, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync still != deb: deb <= sync and counter <= 0.
  - If sync == deb, the counter <= 0.
  - Net latency from a clean raw edge to the deb edge = 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES sync cycles are never seen.
- Edge detect: the registered previous deb level gives one-cycle rise and fall strobes.
- Cursor:
  - On the `next` rise strobe, `cursor` increments; 5 wraps to 0. Value 6 is never reachable.
  - Ignored while the select FSM is not IDLE (select has priority when both buttons are held).
  - Ignored while `active_state`==6.
- Select FSM:
  - IDLE: on `select` rise, go to HOLD with hold_cnt <= 1.
  - HOLD, deb high: hold_cnt increments. The cycle it reaches LONG_PRESS_CYCLES:
    - `rst_req` <= 1 for one cycle;
    - `cursor` <= 2;
    - go to LONG_WAIT.
  - HOLD, `select` fall: go to IDLE.
    - If `active_state` != 6, `change_state` <= cursor for exactly one cycle.
    - If `active_state` == 6, no command is issued.
  - LONG_WAIT: no outputs; on `select` fall go to IDLE. No `change_state` is issued after a long press.
- Output timing:
  - `change_state` is registered and valid in the cycle after the fall strobe; it returns to 3'd7 the next cycle.
  - `rst_req` is registered with the same one-cycle width.
- Dead state: the long press is still honoured, giving the revive path.
- Simultaneous events: a `next` rise in the same cycle as a `select` rise is dropped.
- Reset mid-operation: a reset during HOLD or LONG_WAIT aborts with no pulse.
  - A button still held after reset deasserts is treated as a fresh press once debounced.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package `tamagotchi_pkg` holds:
  - state-code constants SALUD=0, HAMBRE=1, SUENO=2, FELICIDAD=3, HIGIENE=4, CONDICION=5, MUERTO=6;
  - NO_CHANGE=3'd7;
  - N_SELECTABLE=6;
  - select FSM encoding IDLE/HOLD/LONG_WAIT.
- One sub-module, `btn_debounce`, instantiated twice. It contains the synchroniser, debounce counter and level output, and is parameterised by DEBOUNCE_CYCLES and CNT_W.

Test Plan:
Run with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=8.
1. Reset, then idle 20 cycles -> `cursor`=2, `change_state`=7 every cycle, `rst_req`=0.
2. Three clean `btn_next` presses (each 10 cycles high, 10 low) -> `cursor` goes 3, 4, 5; a fourth press -> 0. Each update lands 6 cycles after the raw rise.
3. `cursor`=4; `btn_select` high 5 cycles, then low -> exactly one cycle of `change_state`=4, 7 otherwise, `rst_req` never asserted.
4. `btn_select` high 30 cycles -> one `rst_req` pulse 8 debounced cycles after deb rise, `cursor`=2, no `change_state` pulse on release.
5. `btn_next` 1–3 cycle glitches -> `cursor` unchanged. Holding both buttons -> `cursor` unchanged, select short-press command issued.
6. `active_state`=6: `next` press and short select -> no change; long select -> `rst_req` pulses. Asserting `rst` mid-HOLD -> no pulse, outputs at reset values next cycle.
